// File: rtl/lc1602_i2c_stream_if.sv
// Push-side and i2c_master-side signals of the LC1602 stream writer.
interface lc1602_i2c_stream_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             i_valid;
    logic [7:0]       i_data;
    logic             i_rs;
    logic             i_nibble_only;
    logic             i_backlight;
    logic             o_ready;
    logic             o_dropped;
    logic             o_busy;
    logic [LVL_W-1:0] o_level;
    logic             o_i2c_enable;
    logic [7:0]       o_i2c_data;
    logic             i_i2c_busy;

    modport master (
        output i_valid, i_data, i_rs, i_nibble_only, i_backlight, i_i2c_busy,
        input  o_ready, o_dropped, o_busy, o_level, o_i2c_enable, o_i2c_data
    );

    modport slave (
        input  i_valid, i_data, i_rs, i_nibble_only, i_backlight, i_i2c_busy,
        output o_ready, o_dropped, o_busy, o_level, o_i2c_enable, o_i2c_data
    );
endinterface

// File: rtl/lc1602_i2c_stream.sv
// Buffered HD44780 4-bit-mode writer: queued command/data bytes are expanded into
// EN-strobed PCF8574 expander writes, issued one at a time to an external i2c_master.
module lc1602_i2c_stream #(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned RS_BIT      = 0,
    parameter int unsigned RW_BIT      = 1,
    parameter int unsigned EN_BIT      = 2,
    parameter int unsigned BL_BIT      = 3,
    parameter int unsigned SETTLE_US   = 10,
    parameter int unsigned EN_PULSE_US = 10,
    parameter int unsigned CMD_US      = 50,
    parameter int unsigned LONG_US     = 2000
) (
    input logic                i_clk,
    input logic                i_rst,
    lc1602_i2c_stream_if.slave bus
);
    localparam int unsigned US    = CLK_HZ / 1_000_000;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned TW    = $clog2(LONG_US * US + 1);

    localparam logic [TW-1:0] SETTLE_CYC = TW'(SETTLE_US * US);
    localparam logic [TW-1:0] EN_CYC     = TW'(EN_PULSE_US * US);
    localparam logic [TW-1:0] CMD_CYC    = TW'(CMD_US * US);
    localparam logic [TW-1:0] LONG_CYC   = TW'(LONG_US * US);

    typedef struct packed {
        logic       nibble_only;
        logic       rs;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_ACK  = 3'd2,
        S_DONE = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    entry_t           mem [FIFO_DEPTH];
    entry_t           hold;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_d;
    logic [TW-1:0]    phase_delay;
    logic [2:0]       phase;
    logic [2:0]       phase_d;
    logic             enable_d;
    logic [7:0]       data_d;
    logic [7:0]       exp_byte;
    logic [3:0]       ctrl;
    logic [3:0]       nib;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             ready;
    logic             last_phase;
    logic             is_long;
    logic             dropped;
    logic             i2c_enable;
    logic [7:0]       i2c_data;

    // A full FIFO still accepts a push on the cycle the idle FSM pops.
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign pop   = (state == S_IDLE) && !empty;
    assign ready = !full || pop;
    assign push  = bus.i_valid && ready;

    assign last_phase = hold.nibble_only ? (phase == 3'd2) : (phase == 3'd5);
    assign is_long    = !hold.rs && !hold.nibble_only &&
                        ((hold.data == 8'h01) || (hold.data == 8'h02) || (hold.data == 8'h03));

    // Expander byte for the current phase: high nibble for P0..P2, low nibble for P3..P5.
    always_comb begin
        ctrl                = '0;
        ctrl[2'(RS_BIT)]    = hold.rs;
        ctrl[2'(RW_BIT)]    = 1'b0;
        ctrl[2'(EN_BIT)]    = (phase == 3'd1) || (phase == 3'd4);
        ctrl[2'(BL_BIT)]    = bus.i_backlight;
        nib                 = (phase < 3'd3) ? hold.data[7:4] : hold.data[3:0];
        exp_byte            = {nib, ctrl};
    end

    always_comb begin
        phase_delay = '0;
        case (phase)
            3'd0, 3'd3: phase_delay = SETTLE_CYC;
            3'd1, 3'd4: phase_delay = EN_CYC;
            default:    phase_delay = '0;
        endcase
        if (last_phase) begin
            phase_delay = is_long ? LONG_CYC : CMD_CYC;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (!empty)              state_d = S_REQ;
            S_REQ:  if (!bus.i_i2c_busy)     state_d = S_ACK;
            S_ACK:  if (bus.i_i2c_busy)      state_d = S_DONE;
            S_DONE: if (!bus.i_i2c_busy)     state_d = S_WAIT;
            S_WAIT: if (timer == '0)         state_d = last_phase ? S_IDLE : S_REQ;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        enable_d = 1'b0;
        data_d   = i2c_data;
        timer_d  = timer;
        phase_d  = phase;
        case (state)
            S_IDLE: phase_d = '0;
            S_REQ: begin
                if (!bus.i_i2c_busy) begin
                    enable_d = 1'b1;
                    data_d   = exp_byte;
                end
            end
            S_DONE: begin
                if (!bus.i_i2c_busy) begin
                    timer_d = phase_delay;
                end
            end
            S_WAIT: begin
                if (timer != '0) begin
                    timer_d = timer - TW'(1);
                end else begin
                    phase_d = phase + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            hold       <= '0;
            phase      <= '0;
            timer      <= '0;
            i2c_enable <= 1'b0;
            i2c_data   <= '0;
            dropped    <= 1'b0;
        end else begin
            i2c_enable <= enable_d;
            i2c_data   <= data_d;
            timer      <= timer_d;
            phase      <= phase_d;
            dropped    <= bus.i_valid && !ready;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!push && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage is not reset; occupancy and pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{nibble_only: bus.i_nibble_only, rs: bus.i_rs, data: bus.i_data};
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_dropped    = dropped;
    assign bus.o_busy       = !empty || (state != S_IDLE);
    assign bus.o_level      = level;
    assign bus.o_i2c_enable = i2c_enable;
    assign bus.o_i2c_data   = i2c_data;

endmodule

// File: tb/tb_lc1602_i2c_stream.sv
// Scoreboard bench for lc1602_i2c_stream with an i2c_master model that holds busy
// for 20 cycles starting one cycle after each enable pulse.
module tb_lc1602_i2c_stream;
    localparam int SETTLE   = 120;
    localparam int ENP      = 120;
    localparam int CMD      = 600;
    localparam int LONG     = 24000;
    localparam int BUSY_CYC = 20;
    // Busy-fall cycle -> timer load -> request state -> registered enable pulse.
    localparam int REQ_LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic hold_req = 1'b0;
    logic hold_q = 1'b0;
    logic prev_busy = 1'b0;
    int   last_fall = 0;
    int   wr_seen = 0;
    int   last_final = 0;
    logic [7:0] exp_q[$];
    int         gap_q[$];
    logic [7:0] exp_b;
    int         exp_g;

    lc1602_i2c_stream_if #(.FIFO_DEPTH(16)) bus ();

    lc1602_i2c_stream dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // i2c_master model; hold_q stretches busy on demand.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        hold_q <= hold_req;
        if (bus.o_i2c_enable) begin
            busy_cnt <= BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.i_i2c_busy = (busy_cnt != 0) || hold_q;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] xbyte(input logic [3:0] nib, input logic rs,
                                         input logic en, input logic bl);
        return {nib, bl, en, 1'b0, rs};
    endfunction

    // Expected writes and busy-fall-to-enable gaps for one entry (-1: gap not checked).
    task automatic sb_add(input logic [7:0] d, input logic rs, input logic nib,
                          input logic bl, input bit chained);
        logic longc;
        longc = !rs && !nib && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
        exp_q.push_back(xbyte(d[7:4], rs, 1'b0, bl)); gap_q.push_back(chained ? last_final + REQ_LAT + 1 : -1);
        exp_q.push_back(xbyte(d[7:4], rs, 1'b1, bl)); gap_q.push_back(SETTLE + REQ_LAT);
        exp_q.push_back(xbyte(d[7:4], rs, 1'b0, bl)); gap_q.push_back(ENP + REQ_LAT);
        if (!nib) begin
            exp_q.push_back(xbyte(d[3:0], rs, 1'b0, bl)); gap_q.push_back(REQ_LAT);
            exp_q.push_back(xbyte(d[3:0], rs, 1'b1, bl)); gap_q.push_back(SETTLE + REQ_LAT);
            exp_q.push_back(xbyte(d[3:0], rs, 1'b0, bl)); gap_q.push_back(ENP + REQ_LAT);
        end
        last_final = longc ? LONG : CMD;
    endtask

    always @(negedge clk) begin
        if (prev_busy && !bus.i_i2c_busy) last_fall = cyc;
        prev_busy = bus.i_i2c_busy;
        if (bus.o_i2c_enable === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("sb_nonempty", exp_q.size(), 1);
            end else begin
                exp_b = exp_q.pop_front();
                exp_g = gap_q.pop_front();
                check("wr_data", int'(bus.o_i2c_data), int'(exp_b));
                if (exp_g >= 0) check("wr_gap", cyc - last_fall, exp_g);
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic rs, input logic nib, input bit chained);
        @(negedge clk);
        sb_add(d, rs, nib, bus.i_backlight, chained);
        bus.i_valid = 1'b1; bus.i_data = d; bus.i_rs = rs; bus.i_nibble_only = nib;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.o_busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, exp_q.size() + int'(bus.o_busy), 0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (wr_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("write_timeout", wr_seen, target);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_enable"},  int'(bus.o_i2c_enable), 0);
        check({tag, "_data"},    int'(bus.o_i2c_data), 0);
        check({tag, "_dropped"}, int'(bus.o_dropped), 0);
        check({tag, "_busy"},    int'(bus.o_busy), 0);
        check({tag, "_level"},   int'(bus.o_level), 0);
        check({tag, "_ready"},   int'(bus.o_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [7:0] d;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_rs = 1'b0;
        bus.i_nibble_only = 1'b0; bus.i_backlight = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // T1: data byte, then CMD wait before idle.
        push_byte(8'h41, 1'b1, 1'b0, 1'b0);
        wait_idle("t1", 3000);
        check("t1_idle_gap", cyc - last_fall, CMD + 2);

        // T2: clear display, then a chained byte after the long wait.
        push_byte(8'h01, 1'b0, 1'b0, 1'b0);
        push_byte(8'h41, 1'b1, 1'b0, 1'b1);
        wait_idle("t2", 40000);

        // T3: init nibble with backlight off.
        bus.i_backlight = 1'b0;
        push_byte(8'h30, 1'b0, 1'b1, 1'b0);
        wait_idle("t3", 3000);
        check("t3_idle_gap", cyc - last_fall, CMD + 2);
        check("t3_writes", wr_seen, 6 + 12 + 3);
        bus.i_backlight = 1'b1;

        // T4: stall the master mid-entry and overfill the FIFO.
        base = wr_seen;
        push_byte(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_writes(base + 1, 200);
        hold_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("t4_level", int'(bus.o_level), (i < 16) ? i : 16);
            check("t4_ready", int'(bus.o_ready), int'(i < 16));
            if (i > 0) check("t4_no_drop", int'(bus.o_dropped), 0);
            d = 8'($urandom);
            if (i < 16) sb_add(d, 1'b1, 1'b0, 1'b1, 1'b1);
            bus.i_valid = 1'b1; bus.i_data = d; bus.i_rs = 1'b1; bus.i_nibble_only = 1'b0;
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("t4_dropped", int'(bus.o_dropped), 1);
        check("t4_full_level", int'(bus.o_level), 16);
        hold_req = 1'b0;

        // T5: push into the full FIFO on the pop cycle.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_ready && n < 5000);
        check("t5_ready", int'(bus.o_ready), 1);
        check("t5_level_before", int'(bus.o_level), 16);
        sb_add(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.i_valid = 1'b1; bus.i_data = 8'hA5; bus.i_rs = 1'b1; bus.i_nibble_only = 1'b0;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("t5_level_after", int'(bus.o_level), 16);
        check("t5_no_drop", int'(bus.o_dropped), 0);
        wait_idle("t4t5", 40000);

        // T6: reset inside the P4 delay, then a clean byte.
        base = wr_seen;
        push_byte(8'h41, 1'b1, 1'b0, 1'b0);
        wait_writes(base + 5, 2000);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6");
        rst = 1'b0;
        exp_q.delete();
        gap_q.delete();
        push_byte(8'h41, 1'b1, 1'b0, 1'b0);
        wait_idle("t6", 3000);
        check("t6_writes", wr_seen, base + 5 + 6);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
